// File: rtl/axis_frame_loader.sv
// rtl/axis_frame_loader.sv - AXI-Stream loader of one D2Q9 lattice frame into the direction BRAMs
module axis_frame_loader #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                      s00_axis_aclk,
    input  logic                      s00_axis_areset,
    input  logic                      s00_axis_tvalid,
    output logic                      s00_axis_tready,
    input  logic [9*DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                      s00_axis_tlast,
    output logic                      wr_en,
    output logic [ADDRESS_WIDTH-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0]     null_wr,
    output logic [DATA_WIDTH-1:0]     n_wr,
    output logic [DATA_WIDTH-1:0]     ne_wr,
    output logic [DATA_WIDTH-1:0]     e_wr,
    output logic [DATA_WIDTH-1:0]     se_wr,
    output logic [DATA_WIDTH-1:0]     s_wr,
    output logic [DATA_WIDTH-1:0]     sw_wr,
    output logic [DATA_WIDTH-1:0]     w_wr,
    output logic [DATA_WIDTH-1:0]     nw_wr,
    output logic                      frame_ready,
    input  logic                      rd_busy,
    output logic                      frame_error,
    output logic [15:0]               frames_loaded
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_FLUSH,
        S_PUBLISH
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic [ADDRESS_WIDTH-1:0]   r_count;
    logic                       r_wr_en;
    logic [ADDRESS_WIDTH-1:0]   r_wr_addr;
    logic [9*DATA_WIDTH-1:0]    r_wr_data;
    logic                       r_frame_error;
    logic [15:0]                r_frames_loaded;

    logic                       w_tready;
    logic                       w_frame_ready;
    logic                       w_set_error;
    logic                       w_handshake;
    logic                       w_at_last;

    assign w_handshake = s00_axis_tvalid && w_tready;
    assign w_at_last   = (r_count == LAST_ADDR);

    // State register; reset drops any partial frame back to IDLE
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the state-derived tready/frame_ready levels
    always_comb begin
        w_next_state  = r_state;
        w_tready      = 1'b0;
        w_frame_ready = 1'b0;
        w_set_error   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rd_busy) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_tready = 1'b1;
                if (w_handshake) begin
                    if (w_at_last) begin
                        if (s00_axis_tlast) begin
                            w_next_state = S_FLUSH;
                        end else begin
                            // Too many beats: keep accepting but stop writing
                            w_set_error  = 1'b1;
                            w_next_state = S_DRAIN;
                        end
                    end else if (s00_axis_tlast) begin
                        // Too few beats: the frame is never published
                        w_set_error  = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                w_tready = 1'b1;
                if (w_handshake && s00_axis_tlast) begin
                    w_next_state = S_IDLE;
                end
            end
            S_FLUSH: begin
                // One spare cycle so the last registered write reaches BRAM
                w_next_state = S_PUBLISH;
            end
            S_PUBLISH: begin
                w_frame_ready = 1'b1;
                if (rd_busy) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Registered BRAM write port, node counter, sticky error and publish counter
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            r_count         <= '0;
            r_wr_en         <= 1'b0;
            r_wr_addr       <= '0;
            r_wr_data       <= '0;
            r_frame_error   <= 1'b0;
            r_frames_loaded <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (r_state == S_LOAD && w_handshake) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_count;
                r_wr_data <= s00_axis_tdata;
                // Any frame-ending beat restarts the count, so the address never wraps
                if (w_at_last || s00_axis_tlast) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
            if (w_set_error) begin
                r_frame_error <= 1'b1;
            end
            if (r_state == S_PUBLISH && rd_busy) begin
                r_frames_loaded <= r_frames_loaded + 16'd1;
            end
        end
    end

    assign s00_axis_tready = w_tready;
    assign frame_ready     = w_frame_ready;
    assign wr_en           = r_wr_en;
    assign wr_addr         = r_wr_addr;
    assign frame_error     = r_frame_error;
    assign frames_loaded   = r_frames_loaded;

    assign null_wr = r_wr_data[9*DATA_WIDTH-1:8*DATA_WIDTH];
    assign n_wr    = r_wr_data[8*DATA_WIDTH-1:7*DATA_WIDTH];
    assign ne_wr   = r_wr_data[7*DATA_WIDTH-1:6*DATA_WIDTH];
    assign e_wr    = r_wr_data[6*DATA_WIDTH-1:5*DATA_WIDTH];
    assign se_wr   = r_wr_data[5*DATA_WIDTH-1:4*DATA_WIDTH];
    assign s_wr    = r_wr_data[4*DATA_WIDTH-1:3*DATA_WIDTH];
    assign sw_wr   = r_wr_data[3*DATA_WIDTH-1:2*DATA_WIDTH];
    assign w_wr    = r_wr_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign nw_wr   = r_wr_data[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_axis_frame_loader.sv
// tb/tb_axis_frame_loader.sv - scoreboard bench for axis_frame_loader
module tb_axis_frame_loader;

    localparam int DEPTH = 2500;

    logic         clk = 1'b0;
    logic         areset = 1'b0;
    logic         tvalid = 1'b0;
    logic         tready;
    logic [143:0] tdata = '0;
    logic         tlast = 1'b0;
    logic         wr_en;
    logic [11:0]  wr_addr;
    logic [15:0]  null_wr, n_wr, ne_wr, e_wr, se_wr, s_wr, sw_wr, w_wr, nw_wr;
    logic         frame_ready;
    logic         rd_busy = 1'b0;
    logic         frame_error;
    logic [15:0]  frames_loaded;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_writes = 0;

    typedef struct {
        int           cyc;
        logic [11:0]  addr;
        logic [143:0] data;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        bit do_reset;
        int nbeats;
        int tlast_at;
        int gap;
        int exp_writes;
        bit exp_ready;
        bit exp_error;
        int exp_loaded;
    } vec_t;
    vec_t tbl[5];

    axis_frame_loader #(.DATA_WIDTH(16), .DEPTH(DEPTH), .ADDRESS_WIDTH(12)) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (areset),
        .s00_axis_tvalid (tvalid),
        .s00_axis_tready (tready),
        .s00_axis_tdata  (tdata),
        .s00_axis_tlast  (tlast),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .null_wr         (null_wr),
        .n_wr            (n_wr),
        .ne_wr           (ne_wr),
        .e_wr            (e_wr),
        .se_wr           (se_wr),
        .s_wr            (s_wr),
        .sw_wr           (sw_wr),
        .w_wr            (w_wr),
        .nw_wr           (nw_wr),
        .frame_ready     (frame_ready),
        .rd_busy         (rd_busy),
        .frame_error     (frame_error),
        .frames_loaded   (frames_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Each direction gets its own tag in the top nibble so slice swaps are visible
    function automatic logic [143:0] beat_data(input int node);
        logic [143:0] v;
        logic [3:0]   d4;
        logic [11:0]  n12;
        v   = '0;
        n12 = node[11:0];
        for (int d = 0; d < 9; d++) begin
            d4 = d[3:0];
            v[143-16*d -: 16] = {d4, n12};
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon();
        if (wr_en) begin
            n_writes++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%0d expected no write", wr_addr);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (wr_addr !== e.addr || cyc != e.cyc + 1 ||
                    {null_wr, n_wr, ne_wr, e_wr, se_wr, s_wr, sw_wr, w_wr, nw_wr} !== e.data) begin
                    n_bad++;
                    $display("FAIL write: got addr=%0d cyc=%0d data=%h expected addr=%0d cyc=%0d data=%h",
                             wr_addr, cyc, {null_wr, n_wr, ne_wr, e_wr, se_wr, s_wr, sw_wr, w_wr, nw_wr},
                             e.addr, e.cyc + 1, e.data);
                end
            end
        end
    endtask

    task automatic do_reset(input logic valid_during);
        @(negedge clk);
        areset  = 1'b1;
        rd_busy = 1'b0;
        tvalid  = valid_during;
        tdata   = beat_data(1200);
        tlast   = 1'b0;
        @(negedge clk);
        areset = 1'b0;
        tvalid = 1'b0;
        check("reset_ctrl", {tready, wr_en, frame_ready, frame_error, wr_addr, frames_loaded}, '0);
        check("reset_data", {null_wr, n_wr, ne_wr, e_wr, se_wr, s_wr, sw_wr, w_wr, nw_wr}, '0);
        sb.delete();
    endtask

    task automatic run_frame(input int nbeats, input int tlast_at, input int gap, input logic exp_ready);
        int beat;
        int budget;
        beat     = 0;
        budget   = 0;
        n_writes = 0;
        while (beat < nbeats && budget < 20000) begin
            @(negedge clk);
            budget++;
            mon();
            tvalid = ($urandom_range(99) >= gap);
            if (tvalid) begin
                tdata = beat_data(beat);
                tlast = (beat == tlast_at);
            end else begin
                tdata = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
                tlast = 1'($urandom_range(1));
            end
            if (tvalid && tready) begin
                if (beat < DEPTH) sb.push_back('{cyc, 12'(beat), beat_data(beat)});
                beat++;
            end
        end
        if (beat < nbeats) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_timeout: got %0d beats expected %0d", beat, nbeats);
        end
        @(negedge clk);
        mon();
        tvalid = 1'b0;
        tlast  = 1'b0;
        check("frame_ready_during_flush", frame_ready, 1'b0);
        if (tlast_at >= 0) check("tready_after_last", tready, 1'b0);
        @(negedge clk);
        mon();
        check("frame_ready", frame_ready, exp_ready);
        check("queue_drained", sb.size(), 0);
    endtask

    initial begin
        int bad;
        tbl[0] = '{1'b1, 2500, 2499,  0, 2500, 1'b1, 1'b0, 1};
        tbl[1] = '{1'b0, 2500, 2499, 40, 2500, 1'b1, 1'b0, 2};
        tbl[2] = '{1'b1,  100,   99, 20,  100, 1'b0, 1'b1, 0};
        tbl[3] = '{1'b0, 2500, 2499, 10, 2500, 1'b1, 1'b1, 1};
        tbl[4] = '{1'b1, 2503, 2502, 30, 2500, 1'b0, 1'b1, 0};

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].do_reset) do_reset(1'b0);
            run_frame(tbl[i].nbeats, tbl[i].tlast_at, tbl[i].gap, tbl[i].exp_ready);
            check("write_count", n_writes, tbl[i].exp_writes);
            check("frame_error", frame_error, tbl[i].exp_error);
            if (tbl[i].exp_ready) begin
                rd_busy = 1'b1;
                @(negedge clk);
                check("frame_ready_drop", frame_ready, 1'b0);
                rd_busy = 1'b0;
            end
            check("frames_loaded", frames_loaded, tbl[i].exp_loaded);
        end

        // Downstream busy holds the loader off; release restarts it after one IDLE cycle
        do_reset(1'b0);
        run_frame(2500, 2499, 0, 1'b1);
        rd_busy = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tready !== 1'b0 || frame_ready !== 1'b0 || wr_en !== 1'b0) bad++;
        end
        check("held_off_cycles", bad, 0);
        check("frames_loaded_held", frames_loaded, 16'd1);
        rd_busy = 1'b0;
        check("tready_still_idle", tready, 1'b0);
        @(negedge clk);
        check("tready_resume", tready, 1'b1);

        // Reset in the middle of a frame, then a clean frame from address 0
        run_frame(1200, -1, 0, 1'b0);
        check("partial_writes", n_writes, 1200);
        do_reset(1'b1);
        run_frame(2500, 2499, 25, 1'b1);
        check("write_count_after_reset", n_writes, 2500);
        check("frame_error_after_reset", frame_error, 1'b0);
        rd_busy = 1'b1;
        @(negedge clk);
        check("frame_ready_drop_after_reset", frame_ready, 1'b0);
        check("frames_loaded_after_reset", frames_loaded, 16'd1);
        rd_busy = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_frame_loader.md
Name: axis_frame_loader

Overview:
- AXI-Stream slave that receives one full D2Q9 lattice frame from the host DMA: 2500 nodes, one 144-bit beat per node holding all 9 directions.
- Writes each beat into the per-direction distribution BRAMs at address = node index.
- Publishes frame_ready to the downstream BRAM streaming controller once the whole frame is resident.
- Refuses to overwrite BRAM while the downstream controller is still streaming out the previous frame.

Parameters:
DATA_WIDTH, 16, width of one direction value
DEPTH, 2500, nodes per frame (50x50 lattice)
ADDRESS_WIDTH, 12, BRAM address width

Ports:
s00_axis_aclk  in  1  single clock for the whole block
s00_axis_areset  in  1  synchronous, active-high reset
s00_axis_tvalid  in  1  beat valid
s00_axis_tready  out  1  beat accepted when tvalid && tready
s00_axis_tdata  in  144  {null, n, ne, e, se, s, sw, w, nw}, MSB first, 16 bits each
s00_axis_tlast  in  1  last beat of frame
wr_en  out  1  BRAM write strobe, common to all 9 direction BRAMs
wr_addr  out  ADDRESS_WIDTH  BRAM write address
n_wr, null_wr, ne_wr, e_wr, se_wr, s_wr, sw_wr, w_wr, nw_wr  out  16 each  per-direction write data
frame_ready  out  1  level; frame resident in BRAM
rd_busy  in  1  downstream controller is streaming the frame out
frame_error  out  1  sticky framing error
frames_loaded  out  16  count of successfully published frames, wraps at 65535->0

Behaviour:
- Reset (synchronous, active-high, sampled on posedge s00_axis_aclk):
  - State goes to IDLE and the beat count goes to 0.
  - All outputs go to 0: tready, wr_en, wr_addr, all *_wr, frame_ready, frame_error, frames_loaded.
  - Reset mid-frame discards the partial frame; no frame_ready is raised for it.
- States:
  - IDLE: tready=0. When rd_busy==0, go to LOAD next cycle.
  - LOAD: tready=1. On each handshake, register wr_en=1, wr_addr=count and the 9 slices, then count++. wr_en is 0 on every cycle without a handshake.
    - Handshake with count==DEPTH-1 and tlast=1: go to FLUSH.
    - Handshake with count==DEPTH-1 and tlast=0 (long frame): set frame_error, go to DRAIN.
    - Handshake with count<DEPTH-1 and tlast=1 (short frame): set frame_error, reset count to 0, go to IDLE. That beat is still written; no publish.
  - DRAIN: tready=1, wr_en=0, beats are discarded. The tlast handshake sends the block to IDLE with count=0. No publish.
  - FLUSH: one cycle. tready=0. Guarantees the final BRAM write has landed before publish.
  - PUBLISH: frame_ready=1, tready=0, held until rd_busy==1 is sampled. On that cycle, frames_loaded++, count=0, go to IDLE; frame_ready drops the following cycle.
- Latency:
  - Beat handshake at cycle T produces the write at T+1 (registered outputs).
  - The last beat at T gives FLUSH at T+1 and frame_ready=1 from T+2.
- Slicing: null_wr=tdata[143:128], n_wr=[127:112], ne_wr=[111:96], e_wr=[95:80], se_wr=[79:64], s_wr=[63:48], sw_wr=[47:32], w_wr=[31:16], nw_wr=[15:0].
- wr_addr covers 0..DEPTH-1 only; it never wraps within a frame.
- tvalid may toggle arbitrarily. tdata/tlast are sampled only on a handshake.
- rd_busy high while in LOAD has no effect. The block enters LOAD only from IDLE, so this occurs only if downstream misbehaves.
- frame_error is cleared only by reset.

Test Plan:
- Reset, rd_busy=0, stream 2500 beats with tdata = {9{node[15:0]}} and tlast on beat 2499.
  - Expect wr_addr 0..2499, each write 1 cycle after its handshake, with ne_wr==addr.
  - Expect frame_ready=1 two cycles after the last handshake.
  - Raise rd_busy: frame_ready=0 next cycle, frames_loaded=1.
- Same frame with tvalid toggled by random 40% gaps: exactly 2500 writes, no duplicates, identical contents.
- After publish, hold rd_busy=1 for 100 cycles: tready stays 0. Drop rd_busy: tready=1 from the cycle after next.
- Short frame, tlast on beat 99: frame_error=1, 100 writes, no frame_ready, back in IDLE. A following good frame publishes; frames_loaded=1.
- Long frame of 2503 beats, tlast on beat 2502: 2500 writes, 3 beats accepted and discarded, frame_error=1, no frame_ready.
- Assert s00_axis_areset at beat 1200: all outputs 0 next cycle. A new full frame then writes from addr 0 and publishes normally.
